mmio_timer: RTL and testbench



---
 rtl/mmio_timer.sv | 106 ++++++++++
 tb/tb_mmio_timer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped down-counter with CTRL/PRESET/COUNT and masked IRQ
module mmio_timer #(
  parameter int CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t                 state, next_state;
  logic                   en, im, irq_flag;
  logic [1:0]             mode;
  logic [CNT_WIDTH-1:0]   preset, count;
  logic                   ctrl_wr, preset_wr;
  logic                   load_cnt, dec_cnt, set_flag, clr_flag, clr_en;
  logic                   unused_bits;

  assign ctrl_wr     = WE && (Addr[3:2] == 2'd0);
  assign preset_wr   = WE && (Addr[3:2] == 2'd1);
  assign unused_bits = ^{Addr[31:4], Addr[1:0], Din};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Mode 1 is auto-reload; every other mode value behaves as one-shot.
  always_comb begin
    next_state = state;
    load_cnt   = 1'b0;
    dec_cnt    = 1'b0;
    set_flag   = 1'b0;
    clr_flag   = 1'b0;
    clr_en     = 1'b0;
    case (state)
      S_IDLE: if (en) next_state = S_LOAD;
      S_LOAD: begin
        load_cnt   = 1'b1;
        next_state = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          next_state = S_IDLE;
        end else if (count == '0) begin
          next_state = S_INT;
          set_flag   = 1'b1;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      default: begin
        if (mode == 2'd1) begin
          clr_flag   = 1'b1;
          next_state = en ? S_LOAD : S_IDLE;
        end else begin
          clr_en     = 1'b1;
          next_state = S_IDLE;
        end
      end
    endcase
  end

  // A bus write to CTRL outranks the one-shot auto-disable and clears a pending flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en       <= 1'b0;
      mode     <= 2'd0;
      im       <= 1'b0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en   <= Din[0];
        mode <= Din[2:1];
        im   <= Din[3];
      end else if (clr_en) begin
        en <= 1'b0;
      end
      if (preset_wr) preset <= Din[CNT_WIDTH-1:0];
      if (load_cnt)     count <= preset;
      else if (dec_cnt) count <= count - CNT_WIDTH'(1);
      if (set_flag)                 irq_flag <= 1'b1;
      else if (ctrl_wr || clr_flag) irq_flag <= 1'b0;
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      2'd0:    Dout = {28'd0, im, mode, en};
      2'd1:    Dout = 32'(preset);
      2'd2:    Dout = 32'(count);
      default: Dout = '0;
    endcase
  end

  assign IRQ = im & irq_flag;

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - directed/randomized bench for mmio_timer against closed-form timing model
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Addr, Din, dout, dout8;
  logic        WE, irq, irq8_unused;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mmio_timer #(.CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(dout), .IRQ(irq)
  );

  mmio_timer #(.CNT_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(dout8), .IRQ(irq8_unused)
  );

  // COUNT after edge k (k>=2) when enabled at edge 0 with PRESET n.
  function automatic logic [31:0] m_count(input int n, input int k, input bit reload);
    int r;
    if (!reload) return ((k - 2) <= n) ? 32'(n - (k - 2)) : 32'd0;
    r = (k - 2) % (n + 3);
    return (r <= n) ? 32'(n - r) : 32'd0;
  endfunction

  // irq_flag after edge k: set from edge n+3; one-shot holds it, auto-reload pulses every n+3.
  function automatic logic m_irq(input int n, input int k, input bit reload);
    int t;
    t = n + 3;
    if (k < t) return 1'b0;
    return reload ? ((k - t) % t == 0) : 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    Addr = BASE | {28'd0, off, 2'b00};
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
    Addr = BASE | {28'd0, off, 2'b00};
    #1;
    check(tag, dout, exp);
  endtask

  task automatic check_reg8(input string tag, input logic [1:0] off, input logic [31:0] exp);
    Addr = BASE | {28'd0, off, 2'b00};
    #1;
    check(tag, dout8, exp);
  endtask

  initial begin
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = BASE;
    Din   = 32'd0;
    #1;
    check_reg("rst_ctrl", 2'd0, 32'd0);
    check_reg("rst_preset", 2'd1, 32'd0);
    check_reg("rst_count", 2'd2, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // One-shot, including modes 2/3 which read back as written
    for (int it = 0; it < 3; it++) begin
      int n;
      logic [1:0] m;
      logic [3:0] cv;
      n  = (it == 0) ? 3 : int'($urandom_range(1, 6));
      m  = (it == 0) ? 2'd0 : ((($urandom & 1) != 0) ? 2'd2 : 2'd3);
      cv = {1'b1, m, 1'b1};
      wr(2'd1, 32'(n));
      wr(2'd0, {28'd0, cv});
      for (int k = 1; k <= n + 5; k++) begin
        tick();
        if (k >= 2) check_reg("os_count", 2'd2, m_count(n, k, 1'b0));
        check("os_irq", 32'(irq), 32'(m_irq(n, k, 1'b0)));
        check_reg("os_ctrl", 2'd0, (k >= n + 4) ? {28'd0, cv & 4'hE} : {28'd0, cv});
      end
      wr(2'd0, 32'h8);
      check("os_clear_irq", 32'(irq), 32'd0);
    end

    // Auto-reload over four periods
    for (int it = 0; it < 2; it++) begin
      int p;
      p = (it == 0) ? 2 : int'($urandom_range(1, 4));
      wr(2'd1, 32'(p));
      wr(2'd0, 32'hB);
      for (int k = 1; k <= 2 + 4 * (p + 3); k++) begin
        tick();
        if (k >= 2) check_reg("ar_count", 2'd2, m_count(p, k, 1'b1));
        check("ar_irq", 32'(irq), 32'(m_irq(p, k, 1'b1)));
      end
      wr(2'd0, 32'h0);
      repeat (4) tick();
      check("ar_stop_irq", 32'(irq), 32'd0);
    end

    // Mask: flag sets internally but IRQ stays low; CTRL write clears the flag
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("mask_irq", 32'(irq), 32'd0);
    end
    check_reg("mask_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    check("unmask_irq0", 32'(irq), 32'd0);
    tick();
    check("unmask_irq1", 32'(irq), 32'd0);
    check_reg("unmask_ctrl", 2'd0, 32'h8);

    // Pause at COUNT=6, re-enable reloads, then CTRL write colliding with INT
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k >= 2) check_reg("pause_run", 2'd2, m_count(10, k, 1'b0));
    end
    wr(2'd0, 32'h8);
    check_reg("pause_at", 2'd2, 32'd6);
    repeat (3) begin
      tick();
      check_reg("pause_hold", 2'd2, 32'd6);
    end
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 13; k++) begin
      tick();
      check_reg("resume_count", 2'd2, (k < 2) ? 32'd6 : m_count(10, k, 1'b0));
      check("resume_irq", 32'(irq), 32'(m_irq(10, k, 1'b0)));
    end
    wr(2'd0, 32'h9);
    check_reg("coll_ctrl", 2'd0, 32'h9);
    check("coll_irq", 32'(irq), 32'd0);
    tick();
    tick();
    check_reg("coll_reload", 2'd2, 32'd10);
    tick();
    check_reg("coll_dec", 2'd2, 32'd9);
    wr(2'd0, 32'h0);
    repeat (3) tick();

    // Asynchronous reset mid-count
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    repeat (4) tick();
    check_reg("mid_count", 2'd2, 32'd3);
    reset = 1'b1;
    check_reg("arst_ctrl", 2'd0, 32'd0);
    check_reg("arst_preset", 2'd1, 32'd0);
    check_reg("arst_count", 2'd2, 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Register map and PRESET=0 boundary
    wr(2'd2, 32'hFFFF_FFFF);
    check_reg("ro_count", 2'd2, 32'd0);
    wr(2'd3, 32'hFFFF_FFFF);
    check_reg("rsvd_read", 2'd3, 32'd0);
    check_reg("rsvd_no_alias", 2'd1, 32'd0);
    wr(2'd0, 32'hFFFF_FFFF);
    check_reg("ctrl_mask", 2'd0, 32'hF);
    check_reg("ctrl_count", 2'd2, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("p0_irq", 32'(irq), 32'(m_irq(0, k, 1'b0)));
    end
    check_reg("p0_ctrl", 2'd0, 32'hE);
    wr(2'd0, 32'h0);
    check("p0_clear", 32'(irq), 32'd0);

    // PRESET width
    begin
      logic [31:0] r;
      wr(2'd1, 32'hFFFF_FFFF);
      check_reg("w32_preset", 2'd1, 32'hFFFF_FFFF);
      check_reg8("w8_preset", 2'd1, 32'h0000_00FF);
      r = $urandom;
      wr(2'd1, r);
      check_reg("w32_rand", 2'd1, r);
      check_reg8("w8_rand", 2'd1, r & 32'hFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
